// File: rtl/amiga_dtack_gen_if.sv
// 68000-side bus signals between the CPU/decode logic and the DTACK generator.
// All signals are active-low where the name ends in _n.
interface amiga_dtack_gen_if;
  logic as_n;
  logic rome_n;
  logic chip_sel;
  logic dbr_n;
  logic xrdy;
  logic ovr_n;
  logic dtack_n;
  logic berr_n;
  logic busy;

  modport master (
    output as_n, rome_n, chip_sel, dbr_n, xrdy, ovr_n,
    input  dtack_n, berr_n, busy
  );

  modport slave (
    input  as_n, rome_n, chip_sel, dbr_n, xrdy, ovr_n,
    output dtack_n, berr_n, busy
  );
endinterface

// File: rtl/amiga_dtack_gen.sv
// DTACK generator for 68000 ROM and chip-space cycles with wait-state insertion.
// Define AMIGA_DTACK_BERR_EN to build in the bus-error watchdog and BERR state.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no CPU cycle in progress, counters cleared
// S_ROM   | ROM cycle, counting down ROM wait states
// S_CARB  | chip cycle, waiting for Agnus to release the bus and XRDY
// S_CWAIT | chip cycle, counting down chip wait states
// S_UNMAP | unmapped access, never acknowledged
// S_ACK   | DTACK asserted until AS rises
// S_BERR  | BERR asserted until AS rises (watchdog build only)
module amiga_dtack_gen #(
  parameter int unsigned ROM_WAIT  = 2,
  parameter int unsigned CHIP_WAIT = 4,
  parameter int unsigned TIMEOUT   = 1024
) (
  input logic               clk,
  input logic               rst,
  amiga_dtack_gen_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ROM   = 3'd1,
    S_CARB  = 3'd2,
    S_CWAIT = 3'd3,
    S_UNMAP = 3'd4,
    S_ACK   = 3'd5
`ifdef AMIGA_DTACK_BERR_EN
    ,
    S_BERR  = 3'd6
`endif
  } state_t;

  localparam logic [7:0] ROM_LOAD  = 8'(ROM_WAIT);
  localparam logic [7:0] CHIP_LOAD = 8'(CHIP_WAIT);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic       dtack_q;
  logic       berr_q;
  logic       busy_q;
  logic       waiting;

  // States in which the CPU is still waiting for a response; AS rising here aborts.
  assign waiting = (state == S_ROM) || (state == S_CARB) ||
                   (state == S_CWAIT) || (state == S_UNMAP);

`ifdef AMIGA_DTACK_BERR_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  logic [15:0] wd;
  logic [15:0] wd_nxt;
  logic        wd_expired;

  assign wd_expired = waiting && (wd == WD_LAST);
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;

    case (state)
      S_IDLE: begin
        cnt_nxt = 8'd0;
        if (!bus.as_n && bus.ovr_n) begin
          if (!bus.rome_n) begin
            state_nxt = S_ROM;
            cnt_nxt   = ROM_LOAD;
          end else if (bus.chip_sel) begin
            state_nxt = S_CARB;
          end else begin
            state_nxt = S_UNMAP;
          end
        end
      end
      S_ROM: begin
        if (cnt == 8'd0) state_nxt = S_ACK;
        else             cnt_nxt   = cnt - 8'd1;
      end
      S_CARB: begin
        if (bus.dbr_n && bus.xrdy) begin
          state_nxt = S_CWAIT;
          cnt_nxt   = CHIP_LOAD;
        end
      end
      S_CWAIT: begin
        // DMA grabbing the bus forces a fresh arbitration and a full wait count.
        if (!bus.dbr_n) begin
          state_nxt = S_CARB;
        end else if (bus.xrdy) begin
          if (cnt == 8'd0) state_nxt = S_ACK;
          else             cnt_nxt   = cnt - 8'd1;
        end
      end
      S_UNMAP: begin
        state_nxt = S_UNMAP;
      end
      S_ACK: begin
        if (bus.as_n) state_nxt = S_IDLE;
      end
`ifdef AMIGA_DTACK_BERR_EN
      S_BERR: begin
        if (bus.as_n) state_nxt = S_IDLE;
      end
`endif
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

`ifdef AMIGA_DTACK_BERR_EN
    // A normal acknowledge on the same edge takes precedence over the timeout.
    if (wd_expired && (state_nxt != S_ACK)) state_nxt = S_BERR;
`endif

    if (waiting && bus.as_n)                  state_nxt = S_IDLE;
    if ((state != S_IDLE) && !bus.ovr_n)      state_nxt = S_IDLE;
    if (state_nxt == S_IDLE)                  cnt_nxt   = 8'd0;
  end

`ifdef AMIGA_DTACK_BERR_EN
  // Counts the edge that leaves IDLE too, so BERR lands TIMEOUT-1 edges after decode.
  always_comb begin
    wd_nxt = 16'd0;
    if ((state_nxt == S_ROM) || (state_nxt == S_CARB) ||
        (state_nxt == S_CWAIT) || (state_nxt == S_UNMAP)) begin
      wd_nxt = wd + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wd <= 16'd0;
    else     wd <= wd_nxt;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 8'd0;
      dtack_q <= 1'b1;
      berr_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      dtack_q <= (state_nxt != S_ACK);
`ifdef AMIGA_DTACK_BERR_EN
      berr_q  <= (state_nxt != S_BERR);
`else
      berr_q  <= 1'b1;
`endif
      busy_q  <= (state_nxt != S_IDLE);
    end
  end

  assign bus.dtack_n = dtack_q;
  assign bus.berr_n  = berr_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_amiga_dtack_gen.sv
// Directed vector bench for amiga_dtack_gen (ROM_WAIT=2, CHIP_WAIT=4, TIMEOUT=16).
module tb_amiga_dtack_gen;
  localparam int unsigned ROM_WAIT  = 2;
  localparam int unsigned CHIP_WAIT = 4;
  localparam int unsigned TIMEOUT   = 16;

  logic clk = 1'b0;
  logic rst;

  amiga_dtack_gen_if bus ();

  amiga_dtack_gen #(
    .ROM_WAIT (ROM_WAIT),
    .CHIP_WAIT(CHIP_WAIT),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    logic  rst;
    logic  as_n;
    logic  rome_n;
    logic  chip_sel;
    logic  dbr_n;
    logic  xrdy;
    logic  ovr_n;
    logic  exp_dtack_n;
    logic  exp_berr_n;
    logic  exp_busy;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input string tag, input logic r, input logic a,
                              input logic ro, input logic c, input logic d,
                              input logic x, input logic o, input logic edt,
                              input logic eb, input logic ebu);
    vec_t v;
    v.tag = tag; v.rst = r; v.as_n = a; v.rome_n = ro; v.chip_sel = c;
    v.dbr_n = d; v.xrdy = x; v.ovr_n = o;
    v.exp_dtack_n = edt; v.exp_berr_n = eb; v.exp_busy = ebu;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic r, input logic a, input logic ro, input logic c,
                       input logic d, input logic x, input logic o);
    rst          = r;
    bus.as_n     = a;
    bus.rome_n   = ro;
    bus.chip_sel = c;
    bus.dbr_n    = d;
    bus.xrdy     = x;
    bus.ovr_n    = o;
  endtask

  task automatic check(input string tag, input string sig, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %b expected %b at %0t", tag, sig, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic edt, input logic eb,
                               input logic ebu);
    check(tag, "dtack_n", bus.dtack_n, edt);
    check(tag, "berr_n", bus.berr_n, eb);
    check(tag, "busy", bus.busy, ebu);
    check(tag, "exclusive", bus.dtack_n | bus.berr_n, 1'b1);
  endtask

  initial begin
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    //   tag          rst as rom chp dbr xr ovr   dt be bu
    add("reset0",     1, 1, 1, 0, 1, 1, 1,   1, 1, 0);
    add("reset_as",   1, 0, 0, 0, 1, 1, 1,   1, 1, 0);
    add("idle",       0, 1, 1, 0, 1, 1, 1,   1, 1, 0);
    // ROM cycle: decode at n, DTACK at n+3
    add("rom_dec",    0, 0, 0, 0, 1, 1, 1,   1, 1, 1);
    add("rom_w1",     0, 0, 0, 0, 1, 1, 1,   1, 1, 1);
    add("rom_w2",     0, 0, 0, 0, 1, 1, 1,   1, 1, 1);
    add("rom_ack",    0, 0, 0, 0, 1, 1, 1,   0, 1, 1);
    add("rom_hold",   0, 0, 0, 0, 1, 1, 1,   0, 1, 1);
    add("rom_rel",    0, 1, 1, 0, 1, 1, 1,   1, 1, 0);
    // back-to-back: decoded on the edge right after release
    add("b2b_dec",    0, 0, 0, 0, 1, 1, 1,   1, 1, 1);
    add("b2b_w1",     0, 0, 0, 0, 1, 1, 1,   1, 1, 1);
    add("b2b_w2",     0, 0, 0, 0, 1, 1, 1,   1, 1, 1);
    add("b2b_ack",    0, 0, 0, 0, 1, 1, 1,   0, 1, 1);
    add("b2b_rel",    0, 1, 1, 0, 1, 1, 1,   1, 1, 0);
    // ROME beats CHIP_SEL: ROM timing even with DMA holding the chip bus
    add("pri_dec",    0, 0, 0, 1, 0, 1, 1,   1, 1, 1);
    add("pri_w1",     0, 0, 0, 1, 0, 1, 1,   1, 1, 1);
    add("pri_w2",     0, 0, 0, 1, 0, 1, 1,   1, 1, 1);
    add("pri_ack",    0, 0, 0, 1, 0, 1, 1,   0, 1, 1);
    add("pri_rel",    0, 1, 1, 0, 1, 1, 1,   1, 1, 0);
    // chip cycle, DBR low 5 edges then k at e6, DTACK at k+5
    add("dma_dec",    0, 0, 1, 1, 0, 1, 1,   1, 1, 1);
    add("dma_arb2",   0, 0, 1, 1, 0, 1, 1,   1, 1, 1);
    add("dma_arb3",   0, 0, 1, 1, 0, 1, 1,   1, 1, 1);
    add("dma_arb4",   0, 0, 1, 1, 0, 1, 1,   1, 1, 1);
    add("dma_arb5",   0, 0, 1, 1, 0, 1, 1,   1, 1, 1);
    add("dma_k",      0, 0, 1, 1, 1, 1, 1,   1, 1, 1);
    add("dma_w1",     0, 0, 1, 1, 1, 1, 1,   1, 1, 1);
    add("dma_w2",     0, 0, 1, 1, 1, 1, 1,   1, 1, 1);
    add("dma_w3",     0, 0, 1, 1, 1, 1, 1,   1, 1, 1);
    add("dma_w4",     0, 0, 1, 1, 1, 1, 1,   1, 1, 1);
    add("dma_ack",    0, 0, 1, 1, 1, 1, 1,   0, 1, 1);
    add("dma_rel",    0, 1, 1, 0, 1, 1, 1,   1, 1, 0);
    // DBR pulse in CWAIT restarts the count: k=e2, restart k=e6, DTACK at e11
    add("rst_dec",    0, 0, 1, 1, 1, 1, 1,   1, 1, 1);
    add("rst_k",      0, 0, 1, 1, 1, 1, 1,   1, 1, 1);
    add("rst_w1",     0, 0, 1, 1, 1, 1, 1,   1, 1, 1);
    add("rst_w2",     0, 0, 1, 1, 1, 1, 1,   1, 1, 1);
    add("rst_dbr",    0, 0, 1, 1, 0, 1, 1,   1, 1, 1);
    add("rst_k2",     0, 0, 1, 1, 1, 1, 1,   1, 1, 1);
    add("rst_v1",     0, 0, 1, 1, 1, 1, 1,   1, 1, 1);
    add("rst_v2",     0, 0, 1, 1, 1, 1, 1,   1, 1, 1);
    add("rst_v3",     0, 0, 1, 1, 1, 1, 1,   1, 1, 1);
    add("rst_v4",     0, 0, 1, 1, 1, 1, 1,   1, 1, 1);
    add("rst_ack",    0, 0, 1, 1, 1, 1, 1,   0, 1, 1);
    add("rst_rel",    0, 1, 1, 0, 1, 1, 1,   1, 1, 0);
    // XRDY low one cycle in CWAIT: k=e2, DTACK at e8
    add("xr_dec",     0, 0, 1, 1, 1, 1, 1,   1, 1, 1);
    add("xr_k",       0, 0, 1, 1, 1, 1, 1,   1, 1, 1);
    add("xr_w1",      0, 0, 1, 1, 1, 1, 1,   1, 1, 1);
    add("xr_hold",    0, 0, 1, 1, 1, 0, 1,   1, 1, 1);
    add("xr_w2",      0, 0, 1, 1, 1, 1, 1,   1, 1, 1);
    add("xr_w3",      0, 0, 1, 1, 1, 1, 1,   1, 1, 1);
    add("xr_w4",      0, 0, 1, 1, 1, 1, 1,   1, 1, 1);
    add("xr_ack",     0, 0, 1, 1, 1, 1, 1,   0, 1, 1);
    add("xr_rel",     0, 1, 1, 0, 1, 1, 1,   1, 1, 0);
    // AS rises during ROM wait: abort without any DTACK
    add("abt_dec",    0, 0, 0, 0, 1, 1, 1,   1, 1, 1);
    add("abt_as",     0, 1, 1, 0, 1, 1, 1,   1, 1, 0);
    add("abt_idle1",  0, 1, 1, 0, 1, 1, 1,   1, 1, 0);
    add("abt_idle2",  0, 1, 1, 0, 1, 1, 1,   1, 1, 0);
    // OVR low during ACK releases DTACK on that edge
    add("ovr_dec",    0, 0, 0, 0, 1, 1, 1,   1, 1, 1);
    add("ovr_w1",     0, 0, 0, 0, 1, 1, 1,   1, 1, 1);
    add("ovr_w2",     0, 0, 0, 0, 1, 1, 1,   1, 1, 1);
    add("ovr_ack",    0, 0, 0, 0, 1, 1, 1,   0, 1, 1);
    add("ovr_drop",   0, 0, 0, 0, 1, 1, 0,   1, 1, 0);
    add("ovr_rel",    0, 1, 1, 0, 1, 1, 1,   1, 1, 0);
    // OVR low while idle blocks decode
    add("ovr_idle",   0, 0, 0, 0, 1, 1, 0,   1, 1, 0);
    add("ovr_idle2",  0, 1, 1, 0, 1, 1, 1,   1, 1, 0);
    // reset during ACK, then a new cycle with AS still low
    add("rsa_dec",    0, 0, 0, 0, 1, 1, 1,   1, 1, 1);
    add("rsa_w1",     0, 0, 0, 0, 1, 1, 1,   1, 1, 1);
    add("rsa_w2",     0, 0, 0, 0, 1, 1, 1,   1, 1, 1);
    add("rsa_ack",    0, 0, 0, 0, 1, 1, 1,   0, 1, 1);
    add("rsa_rst",    1, 0, 0, 0, 1, 1, 1,   1, 1, 0);
    add("rsa_redec",  0, 0, 0, 0, 1, 1, 1,   1, 1, 1);
    add("rsa_v1",     0, 0, 0, 0, 1, 1, 1,   1, 1, 1);
    add("rsa_v2",     0, 0, 0, 0, 1, 1, 1,   1, 1, 1);
    add("rsa_ack2",   0, 0, 0, 0, 1, 1, 1,   0, 1, 1);
    add("rsa_rel",    0, 1, 1, 0, 1, 1, 1,   1, 1, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].as_n, vecs[i].rome_n, vecs[i].chip_sel,
            vecs[i].dbr_n, vecs[i].xrdy, vecs[i].ovr_n);
      @(posedge clk);
      #1;
      check_outputs(vecs[i].tag, vecs[i].exp_dtack_n, vecs[i].exp_berr_n,
                    vecs[i].exp_busy);
    end

    // Unmapped access: AS low sampled at edge 0 of this loop.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
`ifdef AMIGA_DTACK_BERR_EN
    for (int i = 0; i <= 20; i++) begin
      @(posedge clk);
      #1;
      check_outputs("unmap_wd", 1'b1, (i >= int'(TIMEOUT) - 1) ? 1'b0 : 1'b1, 1'b1);
    end
`else
    for (int i = 0; i < 110; i++) begin
      @(posedge clk);
      #1;
      check_outputs("unmap_nowd", 1'b1, 1'b1, 1'b1);
    end
`endif
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check_outputs("unmap_rel", 1'b1, 1'b1, 1'b0);

    // Chip cycle stuck in CARB is aborted by AS rising.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_outputs("carb_wait", 1'b1, 1'b1, 1'b1);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check_outputs("carb_abort", 1'b1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/amiga_dtack_gen.md
# amiga_dtack_gen

Bus-cycle acknowledge generator for the 68000 side of the Amiga address decode. It consumes the ROM-enable decode (`_ROME`) and a chip-space select, arbitrates against Agnus DMA (`_DBR`) and `XRDY`, and inserts programmable wait states. It then drives `_DTACK` back to the CPU and to the address-decode PAL. An optional watchdog raises `_BERR` on cycles that are never acknowledged.

## Interface

Parameters:
- `ROM_WAIT`, default 2: wait cycles inserted for ROM cycles; range 0–255.
- `CHIP_WAIT`, default 4: wait cycles inserted for chip-space cycles after arbitration; range 0–255.
- `TIMEOUT`, default 1024: cycles from `_AS` sampled low to `_BERR`; range 2–65535.

Ports:
- `CLK` input 1: single system clock; all inputs are sampled and all state changes on its rising edge.
- `RST` input 1: synchronous, active-high reset.
- `_AS` input 1: CPU address strobe, active low, already synchronous to `CLK`.
- `_ROME` input 1: ROM select from the address decode, active low.
- `CHIP_SEL` input 1: chip RAM or custom-register select, active high.
- `_DBR` input 1: Agnus bus request, active low; low means DMA owns the chip bus.
- `XRDY` input 1: external ready, active high.
- `_OVR` input 1: override, active low; when low, this block must not acknowledge.
- `_DTACK` output 1: data acknowledge, active low, registered.
- `_BERR` output 1: bus error, active low, registered.
- `BUSY` output 1: high whenever the FSM is not in IDLE, registered.

## Operation

States and transitions:
- **IDLE**: counters are cleared.
  - If `_AS`=0 and `_OVR`=1 and `_ROME`=0: go to ROM, load `cnt`=`ROM_WAIT`.
  - Otherwise, if `_AS`=0 and `_OVR`=1 and `CHIP_SEL`=1: go to CARB.
  - Otherwise, if `_AS`=0 and `_OVR`=1: go to UNMAP.
  - `_ROME` has priority over `CHIP_SEL`.
- **ROM**: if `cnt`=0, go to ACK; otherwise decrement `cnt`.
- **CARB** (chip arbitration): when `_DBR`=1 and `XRDY`=1, load `cnt`=`CHIP_WAIT` and go to CWAIT; otherwise stay in CARB.
- **CWAIT**:
  - `_DBR`=0: return to CARB; the wait count restarts.
  - `XRDY`=0: hold `cnt`.
  - Otherwise: if `cnt`=0, go to ACK; else decrement `cnt`.
- **UNMAP**: no acknowledge is ever given; the cycle waits for the watchdog or for `_AS` to rise.
- **ACK**: `_DTACK`=0. When `_AS` is sampled at 1, go to IDLE.
- **BERR**: `_BERR`=0. When `_AS` is sampled at 1, go to IDLE.

Abort and override rules:
- `_AS` sampled at 1 in ROM, CARB, CWAIT or UNMAP: go to IDLE on that edge; no acknowledge is issued.
- `_OVR` sampled at 0 in any non-IDLE state: go to IDLE; `_DTACK` and `_BERR` are released (1) on that edge.

Reset and exclusivity:
- Reset: state=IDLE, `_DTACK`=1, `_BERR`=1, `BUSY`=0, `cnt`=0, watchdog=0.
- `_DTACK` and `_BERR` are never low in the same cycle.

## Timing

- Outputs are registered and change on the same edge that enters or leaves ACK or BERR.
- ROM cycle: `_AS` sampled low at edge n, so ROM is entered at n. `_DTACK` goes low at edge n+`ROM_WAIT`+1.
  - `ROM_WAIT`=0 gives `_DTACK` low at edge n+1.
- Chip cycle: first edge k in CARB that samples `_DBR`=1 and `XRDY`=1. `_DTACK` goes low at edge k+`CHIP_WAIT`+1, plus one extra edge for each `XRDY`=0 hold cycle in CWAIT.
- Release: `_DTACK` or `_BERR` rises on the first edge sampling `_AS`=1. Minimum assertion is one cycle.
- Back-to-back cycles: IDLE is re-entered on the release edge, and the next `_AS` low is decoded at the following edge.
- Watchdog: 16-bit counter, zero in IDLE, increments every edge in ROM, CARB, CWAIT and UNMAP.
  - On the edge where it equals `TIMEOUT`-1, go to BERR.
  - If an ACK transition and the timeout occur on the same edge, ACK wins.

## Configuration

- `AMIGA_DTACK_BERR_EN` defined: the watchdog and BERR state are compiled in, as described above.
- Not defined:
  - The watchdog and BERR state are absent and `_BERR` is tied to 1.
  - UNMAP and CARB wait indefinitely, ending only when `_AS` rises, `_OVR` falls, or reset is asserted.

## Test plan

- **ROM cycle**: `ROM_WAIT`=2, `_AS`/`_ROME` low at edge 10 → `_DTACK` low at edge 13. `_AS` high sampled at edge 15 → `_DTACK` high at edge 15, `BUSY`=0.
- **Chip cycle with DMA contention**: `CHIP_SEL`=1, `_DBR` low for 5 cycles, then high at edge k, `CHIP_WAIT`=4 → `_DTACK` low at edge k+5.
  - Pulse `_DBR` low for 1 cycle during CWAIT → the count restarts.
  - Drop `XRDY` for 1 cycle during CWAIT → `_DTACK` is delayed by 1 edge.
- **Unmapped access** with `AMIGA_DTACK_BERR_EN`, `TIMEOUT`=16, `_AS` low at edge 0 → `_BERR` low at edge 15 and `_DTACK` stays 1. Without the macro → `_BERR` stays 1 for 100+ cycles.
- **Abort and override**: `_AS` rises during ROM wait → IDLE with no `_DTACK` pulse. `_OVR` low during ACK → `_DTACK` high on the next edge.
- **Priority and reset**: `_ROME`=0 with `CHIP_SEL`=1 → ROM timing is used.
  - `RST`=1 asserted during ACK → `_DTACK`=1, `_BERR`=1, `BUSY`=0 at that edge.
  - After `RST`=0 with `_AS` still low → a new cycle is decoded.
